// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a single-ported unified memory
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    input  logic                  flush_if,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_valid,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_W-1:0]     dm_addr,
    input  logic [DATA_W-1:0]     dm_wdata,
    input  logic [DATA_W/8-1:0]   dm_be,
    output logic [DATA_W-1:0]     dm_rdata,
    output logic                  dm_valid,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ready,
    output logic                  stall_if,
    output logic                  stall_dm
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} state_t;

    state_t              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
    logic                if_valid_q, if_valid_d;
    logic                dm_valid_q, dm_valid_d;
    logic [3:0]          starve_q, starve_d;
    logic                kill_q, kill_d;

    // A requester that is receiving its valid pulse this cycle is still showing the
    // request it just had served, so it is not eligible for a new grant yet.
    logic if_elig, dm_elig, grant_d, grant_i;
    assign if_elig = if_req & ~if_valid;
    assign dm_elig = dm_req & ~dm_valid_q;
    assign grant_d = (state_q == IDLE) & dm_elig & ~(if_elig & (starve_q == LIMIT));
    assign grant_i = (state_q == IDLE) & if_elig & ~grant_d;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
            starve_q    <= '0;
            kill_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_valid_q  <= if_valid_d;
            dm_valid_q  <= dm_valid_d;
            starve_q    <= starve_d;
            kill_q      <= kill_d;
        end
    end

    // Next-state: grant from IDLE, leave BUSY only when memory completes
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_d)      state_d = BUSY_D;
                else if (grant_i) state_d = BUSY_I;
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latch the granted transaction, capture read data, pulse valids
    always_comb begin
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;
        starve_d    = starve_q;
        kill_d      = kill_q;
        case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (grant_d) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    mem_be_d    = dm_be;
                    if (!if_req)              starve_d = '0;
                    else if (starve_q < LIMIT) starve_d = starve_q + 4'd1;
                end else if (grant_i) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    mem_be_d    = '1;
                    starve_d    = '0;
                    kill_d      = flush_if;
                end
            end
            BUSY_I: begin
                kill_d = kill_q | flush_if;
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    kill_d    = 1'b0;
                    if (!(kill_q | flush_if)) begin
                        if_rdata_d = mem_rdata;
                        if_valid_d = 1'b1;
                    end
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    mem_req_d  = 1'b0;
                    dm_rdata_d = mem_rdata;
                    dm_valid_d = 1'b1;
                end
            end
            default: mem_req_d = 1'b0;
        endcase
    end

    // A redirect in the pulse cycle itself still squashes the fetch response
    assign if_valid  = if_valid_q & ~flush_if;
    assign dm_valid  = dm_valid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign stall_if  = if_req & ~if_valid;
    assign stall_dm  = dm_req & ~dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, flush_if, if_valid;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_valid;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be, mem_be;
    logic        mem_req, mem_we, mem_ready, stall_if, stall_dm;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .flush_if(flush_if),
        .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .stall_if(stall_if), .stall_dm(stall_dm)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // advance one clock; inputs are then driven before the next edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; if_req = 0; if_addr = 0; flush_if = 0;
        dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; dm_be = 0;
        mem_rdata = 0; mem_ready = 0;
        tick(); tick();
        rst = 1'b0;
        settle();
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_be", {28'd0, mem_be}, 32'd0);
        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst_dm_valid", {31'd0, dm_valid}, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_dm_rdata", dm_rdata, 32'd0);

        // fetch only
        if_req = 1; if_addr = 32'h100; mem_ready = 1; mem_rdata = 32'h00500093;
        settle();
        check("f_stall_c1", {31'd0, stall_if}, 32'd1);
        check("f_memreq_c1", {31'd0, mem_req}, 32'd0);
        tick();
        check("f_memreq_c2", {31'd0, mem_req}, 32'd1);
        check("f_addr_c2", mem_addr, 32'h100);
        check("f_be_c2", {28'd0, mem_be}, 32'hf);
        check("f_we_c2", {31'd0, mem_we}, 32'd0);
        check("f_stall_c2", {31'd0, stall_if}, 32'd1);
        check("f_valid_c2", {31'd0, if_valid}, 32'd0);
        tick();
        check("f_valid_c3", {31'd0, if_valid}, 32'd1);
        check("f_rdata_c3", if_rdata, 32'h00500093);
        check("f_stall_c3", {31'd0, stall_if}, 32'd0);
        check("f_memreq_c3", {31'd0, mem_req}, 32'd0);
        if_req = 0;
        tick();
        check("f_valid_c4", {31'd0, if_valid}, 32'd0);
        check("f_idle_c4", {31'd0, mem_req}, 32'd0);

        // simultaneous requests: data first, fetch in the dm_valid cycle
        if_req = 1; if_addr = 32'h104;
        dm_req = 1; dm_we = 0; dm_addr = 32'h2000; dm_be = 4'b0101;
        mem_rdata = 32'h11111111;
        tick();
        check("s_addr_d", mem_addr, 32'h2000);
        check("s_we_d", {31'd0, mem_we}, 32'd0);
        check("s_stall_if", {31'd0, stall_if}, 32'd1);
        check("s_stall_dm", {31'd0, stall_dm}, 32'd1);
        tick();
        check("s_dm_valid", {31'd0, dm_valid}, 32'd1);
        check("s_dm_rdata", dm_rdata, 32'h11111111);
        check("s_stall_dm_v", {31'd0, stall_dm}, 32'd0);
        dm_req = 0; mem_rdata = 32'h22222222;
        tick();
        check("s_dm_valid_off", {31'd0, dm_valid}, 32'd0);
        check("s_addr_i", mem_addr, 32'h104);
        check("s_be_i", {28'd0, mem_be}, 32'hf);
        check("s_memreq_i", {31'd0, mem_req}, 32'd1);
        tick();
        check("s_if_valid", {31'd0, if_valid}, 32'd1);
        check("s_if_rdata", if_rdata, 32'h22222222);
        if_req = 0;
        tick();

        // wait states on a store
        mem_ready = 0;
        dm_req = 1; dm_we = 1; dm_addr = 32'h2004; dm_wdata = 32'hDEADBEEF; dm_be = 4'b0011;
        tick();
        for (int c = 0; c < 6; c++) begin
            if (c == 5) mem_ready = 1;
            settle();
            check("w_memreq", {31'd0, mem_req}, 32'd1);
            check("w_we", {31'd0, mem_we}, 32'd1);
            check("w_addr", mem_addr, 32'h2004);
            check("w_wdata", mem_wdata, 32'hDEADBEEF);
            check("w_be", {28'd0, mem_be}, 32'h3);
            check("w_stall_dm", {31'd0, stall_dm}, 32'd1);
            check("w_dm_valid", {31'd0, dm_valid}, 32'd0);
            tick();
        end
        check("w_dm_valid_pulse", {31'd0, dm_valid}, 32'd1);
        dm_req = 0; dm_we = 0;
        tick();
        check("w_dm_valid_end", {31'd0, dm_valid}, 32'd0);
        check("w_memreq_end", {31'd0, mem_req}, 32'd0);

        // starvation: four data grants with fetch pending, then fetch, then data again
        mem_ready = 1; mem_rdata = 32'h44444444; if_addr = 32'h200; dm_be = 4'hf;
        for (int r = 0; r < 6; r++) begin
            if_req = 1; dm_req = 1; dm_addr = 32'h3000 + 32'(r * 4);
            tick();
            if (r == 4) check("st_grant_fetch", mem_addr, 32'h200);
            else        check("st_grant_data", mem_addr, 32'h3000 + 32'(r * 4));
            tick();
            if (r == 4) check("st_if_valid", {31'd0, if_valid}, 32'd1);
            else        check("st_dm_valid", {31'd0, dm_valid}, 32'd1);
            if_req = 0; dm_req = 0;
            tick();
        end
        check("st_if_rdata", if_rdata, 32'h44444444);

        // flush during BUSY_I
        if_req = 1; if_addr = 32'h300; mem_ready = 0; mem_rdata = 32'h55555555;
        tick();
        flush_if = 1;
        tick();
        flush_if = 0; mem_ready = 1;
        settle();
        check("fl_memreq_busy", {31'd0, mem_req}, 32'd1);
        check("fl_addr_busy", mem_addr, 32'h300);
        if_addr = 32'h400;
        tick();
        check("fl_no_valid", {31'd0, if_valid}, 32'd0);
        check("fl_rdata_kept", if_rdata, 32'h44444444);
        check("fl_completed", {31'd0, mem_req}, 32'd0);
        mem_rdata = 32'h33333333;
        tick();
        check("fl_refetch_addr", mem_addr, 32'h400);
        check("fl_refetch_req", {31'd0, mem_req}, 32'd1);
        tick();
        check("fl_refetch_valid", {31'd0, if_valid}, 32'd1);
        check("fl_refetch_rdata", if_rdata, 32'h33333333);
        if_req = 0;
        tick();

        // reset in the middle of a data transaction
        mem_ready = 0; dm_req = 1; dm_we = 0; dm_addr = 32'h5000;
        tick();
        check("r_busy", {31'd0, mem_req}, 32'd1);
        rst = 1;
        tick();
        rst = 0; dm_req = 0; mem_ready = 1;
        settle();
        check("r_memreq", {31'd0, mem_req}, 32'd0);
        check("r_addr", mem_addr, 32'd0);
        check("r_dm_valid", {31'd0, dm_valid}, 32'd0);
        tick();
        check("r_late_ready_valid", {31'd0, dm_valid}, 32'd0);
        check("r_late_ready_req", {31'd0, mem_req}, 32'd0);
        tick();
        check("r_idle_hold", {31'd0, mem_req}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
